// File: rtl/regfile_sb.sv
// Parametrised register file with write-back bypass and a per-register
// pending-write scoreboard used by decode for RAW detection and issue.
module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  output logic              sr1_busy,
  output logic              sr2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dr,
  output logic              issue_stall,
  input  logic              ldreg,
  input  logic [ADDR_W-1:0] wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              sb_err
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [CNT_W-1:0]  r_cnt  [NREGS];
  logic              r_err;

  logic w_hit1;
  logic w_hit2;
  logic w_hiti;
  logic w_stall;

  assign w_hit1 = ldreg && (wb_dr == sr1);
  assign w_hit2 = ldreg && (wb_dr == sr2);
  assign w_hiti = ldreg && (wb_dr == issue_dr);

  // A write-back to a saturated register frees a slot this cycle.
  assign w_stall = issue_valid && (r_cnt[issue_dr] == CMAX) && !w_hiti;

  always_comb begin
    sr1_out     = '0;
    sr2_out     = '0;
    sr1_busy    = 1'b0;
    sr2_busy    = 1'b0;
    issue_stall = 1'b0;
    if (reset_n) begin
      sr1_out = (BYPASS != 0 && w_hit1) ? wb_data : r_regs[sr1];
      sr2_out = (BYPASS != 0 && w_hit2) ? wb_data : r_regs[sr2];
      sr1_busy = (r_cnt[sr1] > CONE) ||
                 (r_cnt[sr1] == CONE && !w_hit1);
      sr2_busy = (r_cnt[sr2] > CONE) ||
                 (r_cnt[sr2] == CONE && !w_hit2);
      issue_stall = w_stall;
    end
  end

  assign sb_err = r_err;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_err <= 1'b0;
    end else begin
      if (ldreg) r_regs[wb_dr] <= wb_data;
      if (ldreg && !flush && r_cnt[wb_dr] == '0) r_err <= 1'b1;
      for (int i = 0; i < NREGS; i++) begin
        logic v_inc;
        logic v_dec;
        v_inc = issue_valid && !w_stall &&
                (issue_dr == ADDR_W'(i));
        v_dec = ldreg && (wb_dr == ADDR_W'(i)) &&
                (r_cnt[i] != '0);
        if (flush) r_cnt[i] <= '0;
        else if (v_inc && !v_dec) r_cnt[i] <= r_cnt[i] + CONE;
        else if (v_dec && !v_inc) r_cnt[i] <= r_cnt[i] - CONE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random
// traffic against an array-based model of the scoreboard rules.
module tb_regfile_sb;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [2:0]  sr1, sr2, issue_dr, wb_dr;
  logic [15:0] sr1_out, sr2_out, wb_data;
  logic        sr1_busy, sr2_busy, issue_valid, issue_stall;
  logic        ldreg, sb_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_reg [8];
  int          m_cnt [8];
  bit          m_err;

  always #5 clk_50 = ~clk_50;

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .CNT_W(2), .BYPASS(1)) dut (
    .clk_50(clk_50), .reset_n(reset_n), .flush(flush),
    .sr1(sr1), .sr2(sr2), .sr1_out(sr1_out), .sr2_out(sr2_out),
    .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
    .issue_valid(issue_valid), .issue_dr(issue_dr),
    .issue_stall(issue_stall), .ldreg(ldreg), .wb_dr(wb_dr),
    .wb_data(wb_data), .sb_err(sb_err)
  );

  function automatic logic [15:0] exp_out(input logic [2:0] a);
    if (ldreg && wb_dr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    int left;
    left = m_cnt[a] - ((ldreg && wb_dr == a) ? 1 : 0);
    return left > 0;
  endfunction

  function automatic logic exp_stall();
    return issue_valid && m_cnt[issue_dr] == 3 &&
           !(ldreg && wb_dr == issue_dr);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_dr = 0;
    ldreg = 0; wb_dr = 0; wb_data = 0;
  endtask

  task automatic tick();
    int  old [8];
    bit  st;
    st = exp_stall();
    @(posedge clk_50);
    for (int i = 0; i < 8; i++) old[i] = m_cnt[i];
    if (flush) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      if (issue_valid && !st) m_cnt[issue_dr] += 1;
      if (ldreg && old[wb_dr] > 0) m_cnt[wb_dr] -= 1;
      if (ldreg && old[wb_dr] == 0) m_err = 1;
    end
    if (ldreg) m_reg[wb_dr] = wb_data;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    reset_n = 0;
    idle();
    model_clear();
    @(negedge clk_50);
    reset_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    sr1 = 0; sr2 = 7; #1;
    checks++;
    if (sr1_out !== 16'h0 || sr2_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got %h %h want 0000 0000", sr1_out, sr2_out);
    end
    checks++;
    if (sr1_busy !== 0 || sr2_busy !== 0 || sb_err !== 0 || issue_stall !== 0) begin
      failures++;
      $display("FAIL reset_flags got b%b%b e%b s%b want 0", sr1_busy,
               sr2_busy, sb_err, issue_stall);
    end
  endtask

  task automatic test_bypass();
    ldreg = 1; wb_dr = 3; wb_data = 16'h0011; sr1 = 3; sr2 = 0; #1;
    checks++;
    if (sr1_out !== 16'h0011) begin
      failures++;
      $display("FAIL bypass_same_cycle got %h want 0011", sr1_out);
    end
    tick();
    ldreg = 0; sr2 = 3; #1;
    checks++;
    if (sr1_out !== 16'h0011 || sr2_out !== 16'h0011) begin
      failures++;
      $display("FAIL bypass_stored got %h %h want 0011", sr1_out, sr2_out);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    sr1 = 5; issue_valid = 1; issue_dr = 5;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (issue_stall !== 0) begin
        failures++;
        $display("FAIL sat_issue%0d stall got %b want 0", k, issue_stall);
      end
      tick();
    end
    #1;
    checks++;
    if (sr1_busy !== 1 || issue_stall !== 1) begin
      failures++;
      $display("FAIL sat_full busy %b stall %b want 1 1", sr1_busy, issue_stall);
    end
    tick();
    ldreg = 1; wb_dr = 5; wb_data = 16'h5555; #1;
    checks++;
    if (issue_stall !== 0) begin
      failures++;
      $display("FAIL sat_wb_frees stall got %b want 0", issue_stall);
    end
    tick();
    ldreg = 0; #1;
    checks++;
    if (issue_stall !== 1 || m_cnt[5] != 3) begin
      failures++;
      $display("FAIL sat_hold stall got %b want 1", issue_stall);
    end
    issue_valid = 0;
    for (int k = 0; k < 3; k++) begin
      ldreg = 1; wb_dr = 5; tick();
    end
    ldreg = 0; #1;
    checks++;
    if (sr1_busy !== 0 || sb_err !== 0) begin
      failures++;
      $display("FAIL sat_drain busy %b err %b want 0 0", sr1_busy, sb_err);
    end
  endtask

  task automatic test_release();
    do_reset();
    issue_valid = 1; issue_dr = 2; tick();
    issue_valid = 0;
    ldreg = 1; wb_dr = 2; wb_data = 16'h0014; sr2 = 2; #1;
    checks++;
    if (sr2_busy !== 0 || sr2_out !== 16'h0014) begin
      failures++;
      $display("FAIL release_same busy %b data %h want 0 0014", sr2_busy, sr2_out);
    end
    tick();
    ldreg = 0; #1;
    checks++;
    if (sr2_busy !== 0 || sb_err !== 0) begin
      failures++;
      $display("FAIL release_next busy %b err %b want 0 0", sr2_busy, sb_err);
    end
  endtask

  task automatic test_underflow();
    logic [15:0] d;
    d = 16'($urandom);
    ldreg = 1; wb_dr = 6; wb_data = d; sr1 = 6;
    tick();
    ldreg = 0;
    repeat (3) tick();
    checks++;
    if (sr1_out !== d || sb_err !== 1) begin
      failures++;
      $display("FAIL underflow data %h err %b want %h 1", sr1_out, sb_err, d);
    end
    do_reset();
    checks++;
    if (sb_err !== 0) begin
      failures++;
      $display("FAIL underflow_clear err got %b want 0", sb_err);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue_valid = 1; issue_dr = 1; tick(); tick();
    issue_dr = 4; tick();
    flush = 1; issue_dr = 1;
    ldreg = 1; wb_dr = 4; wb_data = 16'hBEEF;
    tick();
    idle(); sr1 = 1; sr2 = 4; #1;
    checks++;
    if (sr1_busy !== 0 || sr2_busy !== 0 || sr2_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL flush busy %b%b data %h want 00 beef", sr1_busy,
               sr2_busy, sr2_out);
    end
    checks++;
    if (sb_err !== 0) begin
      failures++;
      $display("FAIL flush_err got %b want 0", sb_err);
    end
    issue_valid = 1; issue_dr = 1; tick();
    issue_valid = 0; #2;
    reset_n = 0; #1;
    checks++;
    if (sr1_busy !== 0 || sr2_out !== 16'h0 || sr1_out !== 16'h0) begin
      failures++;
      $display("FAIL async_reset busy %b data %h want 0 0000", sr1_busy, sr2_out);
    end
    model_clear();
    @(negedge clk_50);
    reset_n = 1; #1;
    checks++;
    if (sr1_busy !== 0 || sr2_out !== 16'h0) begin
      failures++;
      $display("FAIL after_reset busy %b data %h want 0 0000", sr1_busy, sr2_out);
    end
  endtask

  task automatic test_random();
    int pick;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      sr1 = 3'($urandom); sr2 = 3'($urandom);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_dr = 3'($urandom_range(0, 3));
      flush = ($urandom_range(0, 39) == 0);
      ldreg = ($urandom_range(0, 9) < 5);
      wb_data = 16'($urandom);
      pick = $urandom_range(0, 7);
      for (int k = 0; k < 8; k++)
        if (m_cnt[(pick + k) % 8] > 0) begin
          pick = (pick + k) % 8;
          break;
        end
      wb_dr = 3'(pick);
      if (n > 500) wb_dr = 3'($urandom);
      #1;
      checks++;
      if (sr1_out !== exp_out(sr1) || sr2_out !== exp_out(sr2)) begin
        failures++;
        $display("FAIL rnd_data n=%0d got %h %h want %h %h", n, sr1_out,
                 sr2_out, exp_out(sr1), exp_out(sr2));
      end
      checks++;
      if (sr1_busy !== exp_busy(sr1) || sr2_busy !== exp_busy(sr2)) begin
        failures++;
        $display("FAIL rnd_busy n=%0d got %b%b want %b%b", n, sr1_busy,
                 sr2_busy, exp_busy(sr1), exp_busy(sr2));
      end
      checks++;
      if (issue_stall !== exp_stall() || sb_err !== m_err) begin
        failures++;
        $display("FAIL rnd_stall_err n=%0d got %b %b want %b %b", n,
                 issue_stall, sb_err, exp_stall(), m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset_n = 1; sr1 = 0; sr2 = 0;
    idle();
    model_clear();
    test_reset();
    test_bypass();
    test_saturate();
    test_release();
    test_underflow();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
